// File: rtl/cap_prop_pkg.sv
// rtl/cap_prop_pkg.sv - shared types, corner table and LFSR step for the cap-lib stimulus driver
//
// Contents:
//   cap_prop_vec_t    one stimulus vector (base, len, addr, newBase, newLen)
//   cap_prop_state_t  driver FSM states
//   N_CORNER          number of directed corner vectors issued before the LFSR stream
//   LFSR_TAPS         Galois mask for x^64 + x^63 + x^61 + x^60 + 1 (right-shifting form)
//   lfsr_next()       one LFSR step
//   corner_vec()      directed corner table, newBase/newLen mirror base/len
package cap_prop_pkg;

    localparam int CP_W     = 64;
    localparam int N_CORNER = 8;

    localparam logic [CP_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    localparam logic [CP_W-1:0] C_ZERO = 64'h0;
    localparam logic [CP_W-1:0] C_ONE  = 64'h1;
    localparam logic [CP_W-1:0] C_MAX  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [CP_W-1:0] C_MSB  = 64'h8000_0000_0000_0000;
    localparam logic [CP_W-1:0] C_4K   = 64'h0000_0000_0000_1000;

    typedef struct packed {
        logic [CP_W-1:0] base;
        logic [CP_W-1:0] len;
        logic [CP_W-1:0] addr;
        logic [CP_W-1:0] newBase;
        logic [CP_W-1:0] newLen;
    } cap_prop_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } cap_prop_state_t;

    function automatic logic [CP_W-1:0] lfsr_next(input logic [CP_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : C_ZERO);
    endfunction

    function automatic cap_prop_vec_t corner_vec(input logic [2:0] i);
        logic [CP_W-1:0] b;
        logic [CP_W-1:0] l;
        logic [CP_W-1:0] a;
        case (i)
            3'd0:    begin b = C_ZERO; l = C_ZERO;         a = C_ZERO;         end
            3'd1:    begin b = C_ZERO; l = C_MAX;          a = C_ZERO;         end
            3'd2:    begin b = C_MAX;  l = C_ZERO;         a = C_MAX;          end
            3'd3:    begin b = C_MAX;  l = C_ONE;          a = C_MAX;          end
            3'd4:    begin b = C_ZERO; l = C_MAX;          a = C_MSB;          end
            3'd5:    begin b = C_4K;   l = C_4K;           a = C_4K;           end
            3'd6:    begin b = C_MSB;  l = C_MSB;          a = C_MSB - C_ONE;  end
            default: begin b = C_ONE;  l = C_MAX - C_ONE;  a = C_MAX;          end
        endcase
        corner_vec.base    = b;
        corner_vec.len     = l;
        corner_vec.addr    = a;
        corner_vec.newBase = b;
        corner_vec.newLen  = l;
    endfunction

endpackage

// File: rtl/cap_prop_lfsr.sv
// rtl/cap_prop_lfsr.sv - Galois LFSR advancing STEPS states per step pulse
//
// Ports:
//   CLK     clock
//   RST_N   asynchronous active-low reset (loads the seed)
//   reseed  reload the seed on the next edge
//   step    advance STEPS LFSR states on the next edge
//   q       current LFSR state
module cap_prop_lfsr
    import cap_prop_pkg::*;
#(
    parameter int              ADDR_W = 64,
    parameter logic [ADDR_W-1:0] SEED = 64'hACE1_0000_0000_1,
    parameter int              STEPS  = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              reseed,
    input  logic              step,
    output logic [ADDR_W-1:0] q
);

    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    localparam logic [ADDR_W-1:0] SEED_EFF = (SEED == '0) ? ADDR_W'(1) : SEED;

    logic [ADDR_W-1:0] adv;

    always_comb begin
        adv = q;
        for (int i = 0; i < STEPS; i++) begin
            adv = lfsr_next(adv);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q <= SEED_EFF;
        end else if (reseed) begin
            q <= SEED_EFF;
        end else if (step) begin
            q <= adv;
        end
    end

endmodule

// File: rtl/cap_prop_stim_driver.sv
// rtl/cap_prop_stim_driver.sv - stimulus initiator and verdict scoreboard for cap-lib property checkers
//
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   start                      pulse: begin a run (honoured only in IDLE or DONE)
//   busy, done                 run in progress / run complete (held until next start)
//   vec_valid, vec_ready       vector handshake towards the checker
//   prop_base .. prop_newLen   vector under test
//   res_valid, res_ok          checker verdict (accepted only while waiting for it)
//   pass_cnt, fail_cnt         saturating verdict counters
//   fail_seen                  sticky: a failure occurred this run
//   fail_base/len/addr         first failing vector
module cap_prop_stim_driver
    import cap_prop_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                NUM_VEC   = 1024,
    parameter logic [ADDR_W-1:0] LFSR_SEED = 64'hACE1_0000_0000_1,
    parameter int                CNT_W     = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              vec_valid,
    input  logic              vec_ready,
    output logic [ADDR_W-1:0] prop_base,
    output logic [ADDR_W-1:0] prop_len,
    output logic [ADDR_W-1:0] prop_addr,
    output logic [ADDR_W-1:0] prop_newBase,
    output logic [ADDR_W-1:0] prop_newLen,
    input  logic              res_valid,
    input  logic              res_ok,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              fail_seen,
    output logic [ADDR_W-1:0] fail_base,
    output logic [ADDR_W-1:0] fail_len,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam int              IDX_W    = $clog2(NUM_VEC) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
    localparam logic [IDX_W-1:0] RND_IDX  = IDX_W'(N_CORNER);

    cap_prop_state_t state, state_nxt;
    logic [IDX_W-1:0] idx;
    cap_prop_vec_t    vec_q;
    cap_prop_vec_t    rnd_vec;
    cap_prop_vec_t    load_vec;
    logic [CP_W-1:0]  lfsr_q, r1, r2, r3, r4, r5;
    logic             start_ok, res_acc, is_random;

    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign res_acc   = (state == ST_WAIT) && res_valid;
    assign is_random = (idx >= RND_IDX);

    cap_prop_lfsr #(
        .ADDR_W (CP_W),
        .SEED   (CP_W'(LFSR_SEED)),
        .STEPS  (5)
    ) u_lfsr (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .reseed (start_ok),
        .step   ((state == ST_LOAD) && is_random),
        .q      (lfsr_q)
    );

    // The five intermediate states of one LOAD's worth of stepping, in field order.
    assign r1 = lfsr_next(lfsr_q);
    assign r2 = lfsr_next(r1);
    assign r3 = lfsr_next(r2);
    assign r4 = lfsr_next(r3);
    assign r5 = lfsr_next(r4);

    assign rnd_vec  = '{base: r1, len: r2, addr: r3, newBase: r4, newLen: r5};
    assign load_vec = is_random ? rnd_vec : corner_vec(idx[2:0]);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_ISSUE;
            ST_ISSUE: if (vec_ready) state_nxt = ST_WAIT;
            ST_WAIT:  if (res_valid) state_nxt = (idx < LAST_IDX) ? ST_LOAD : ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_LOAD;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign busy      = (state == ST_LOAD) || (state == ST_ISSUE) || (state == ST_WAIT);
    assign done      = (state == ST_DONE);
    assign vec_valid = (state == ST_ISSUE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx       <= '0;
            vec_q     <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_seen <= 1'b0;
            fail_base <= '0;
            fail_len  <= '0;
            fail_addr <= '0;
        end else if (start_ok) begin
            idx       <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_seen <= 1'b0;
            fail_base <= '0;
            fail_len  <= '0;
            fail_addr <= '0;
        end else begin
            if (state == ST_LOAD) begin
                vec_q <= load_vec;
            end
            if (res_acc) begin
                if (res_ok) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
                end else begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                    if (!fail_seen) begin
                        fail_base <= vec_q.base[ADDR_W-1:0];
                        fail_len  <= vec_q.len[ADDR_W-1:0];
                        fail_addr <= vec_q.addr[ADDR_W-1:0];
                    end
                    fail_seen <= 1'b1;
                end
                // idx parks on the last vector while DONE; start clears it.
                if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
            end
        end
    end

    assign prop_base    = vec_q.base[ADDR_W-1:0];
    assign prop_len     = vec_q.len[ADDR_W-1:0];
    assign prop_addr    = vec_q.addr[ADDR_W-1:0];
    assign prop_newBase = vec_q.newBase[ADDR_W-1:0];
    assign prop_newLen  = vec_q.newLen[ADDR_W-1:0];

endmodule

// File: tb/tb_cap_prop_stim_driver.sv
// tb/tb_cap_prop_stim_driver.sv - directed self-checking bench for cap_prop_stim_driver
module tb_cap_prop_stim_driver;

    localparam int          NV   = 16;
    localparam logic [63:0] MAXV = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] SEED = 64'hACE1_0000_0000_1;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        vec_ready = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_ok = 1'b0;
    logic        busy, done, vec_valid, fail_seen;
    logic [63:0] prop_base, prop_len, prop_addr, prop_newBase, prop_newLen;
    logic [63:0] fail_base, fail_len, fail_addr;
    logic [31:0] pass_cnt, fail_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] e_base [NV];
    logic [63:0] e_len  [NV];
    logic [63:0] e_addr [NV];
    logic [63:0] e_nb   [NV];
    logic [63:0] e_nl   [NV];

    cap_prop_stim_driver #(.NUM_VEC(NV)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .busy(busy), .done(done),
        .vec_valid(vec_valid), .vec_ready(vec_ready),
        .prop_base(prop_base), .prop_len(prop_len), .prop_addr(prop_addr),
        .prop_newBase(prop_newBase), .prop_newLen(prop_newLen),
        .res_valid(res_valid), .res_ok(res_ok),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_seen(fail_seen),
        .fail_base(fail_base), .fail_len(fail_len), .fail_addr(fail_addr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // x^64+x^63+x^61+x^60+1, written bit by bit.
    function automatic logic [63:0] m_step(input logic [63:0] s);
        logic [63:0] n;
        logic        fb;
        fb    = s[0];
        n     = {1'b0, s[63:1]};
        n[63] = fb;
        n[62] = s[63] ^ fb;
        n[60] = s[61] ^ fb;
        n[59] = s[60] ^ fb;
        return n;
    endfunction

    task automatic build_model();
        logic [63:0] m;
        e_base[0] = 64'h0;  e_len[0] = 64'h0;        e_addr[0] = 64'h0;
        e_base[1] = 64'h0;  e_len[1] = MAXV;         e_addr[1] = 64'h0;
        e_base[2] = MAXV;   e_len[2] = 64'h0;        e_addr[2] = MAXV;
        e_base[3] = MAXV;   e_len[3] = 64'h1;        e_addr[3] = MAXV;
        e_base[4] = 64'h0;  e_len[4] = MAXV;         e_addr[4] = MSB;
        e_base[5] = 64'h1000; e_len[5] = 64'h1000;   e_addr[5] = 64'h1000;
        e_base[6] = MSB;    e_len[6] = MSB;          e_addr[6] = 64'h7FFF_FFFF_FFFF_FFFF;
        e_base[7] = 64'h1;  e_len[7] = 64'hFFFF_FFFF_FFFF_FFFE; e_addr[7] = MAXV;
        for (int i = 0; i < 8; i++) begin
            e_nb[i] = e_base[i];
            e_nl[i] = e_len[i];
        end
        m = SEED;
        for (int i = 8; i < NV; i++) begin
            m = m_step(m); e_base[i] = m;
            m = m_step(m); e_len[i]  = m;
            m = m_step(m); e_addr[i] = m;
            m = m_step(m); e_nb[i]   = m;
            m = m_step(m); e_nl[i]   = m;
        end
    endtask

    task automatic pulse_start();
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
    endtask

    // Serves one run: bp_idx gets 10 cycles of backpressure (with a stray verdict
    // and a stray start inside), stop_idx returns in WAIT right after its handshake.
    task automatic serve(input logic [15:0] fmask, input int bp_idx, input int stop_idx);
        int k;
        for (int i = 0; i < NV; i++) begin
            k = 0;
            while (!vec_valid && k < 20) begin
                @(negedge CLK);
                k++;
            end
            if (!vec_valid) begin
                chk($sformatf("vec_valid_timeout[%0d]", i), 64'(vec_valid), 64'h1);
                return;
            end
            chk($sformatf("base[%0d]", i), prop_base, e_base[i]);
            chk($sformatf("len[%0d]", i), prop_len, e_len[i]);
            chk($sformatf("addr[%0d]", i), prop_addr, e_addr[i]);
            chk($sformatf("newBase[%0d]", i), prop_newBase, e_nb[i]);
            chk($sformatf("newLen[%0d]", i), prop_newLen, e_nl[i]);
            if (i == bp_idx) begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge CLK);
                    chk($sformatf("bp_valid[%0d]", c), 64'(vec_valid), 64'h1);
                    chk($sformatf("bp_base[%0d]", c), prop_base, e_base[i]);
                    if (c == 3) begin res_valid = 1'b1; res_ok = 1'b0; end
                    if (c == 4) res_valid = 1'b0;
                    if (c == 6) start = 1'b1;
                    if (c == 7) start = 1'b0;
                end
                chk("bp_pass_cnt", 64'(pass_cnt), 64'(i));
                chk("bp_fail_cnt", 64'(fail_cnt), 64'h0);
            end
            vec_ready = 1'b1;
            @(negedge CLK);
            vec_ready = 1'b0;
            chk($sformatf("hs_valid_drop[%0d]", i), 64'(vec_valid), 64'h0);
            if (i == stop_idx) return;
            @(negedge CLK);
            res_valid = 1'b1;
            res_ok    = !fmask[i];
            @(negedge CLK);
            res_valid = 1'b0;
        end
    endtask

    task automatic end_checks(input int ep, input int ef, input logic es,
                              input logic [63:0] fb, input logic [63:0] fl, input logic [63:0] fa);
        chk("end_done", 64'(done), 64'h1);
        chk("end_busy", 64'(busy), 64'h0);
        chk("end_pass_cnt", 64'(pass_cnt), 64'(ep));
        chk("end_fail_cnt", 64'(fail_cnt), 64'(ef));
        chk("end_fail_seen", 64'(fail_seen), 64'(es));
        chk("end_fail_base", fail_base, fb);
        chk("end_fail_len", fail_len, fl);
        chk("end_fail_addr", fail_addr, fa);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        build_model();
        repeat (3) @(negedge CLK);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_vec_valid", 64'(vec_valid), 64'h0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("idle_busy", 64'(busy), 64'h0);
        chk("idle_done", 64'(done), 64'h0);
        chk("idle_vec_valid", 64'(vec_valid), 64'h0);
        chk("idle_pass_cnt", 64'(pass_cnt), 64'h0);
        chk("idle_fail_cnt", 64'(fail_cnt), 64'h0);
        chk("idle_fail_seen", 64'(fail_seen), 64'h0);
        chk("idle_fail_base", fail_base, 64'h0);
        chk("idle_prop_base", prop_base, 64'h0);

        // Stray verdict while idle.
        res_valid = 1'b1; res_ok = 1'b1;
        @(negedge CLK); res_valid = 1'b0;
        @(negedge CLK);
        chk("idle_spurious_pass", 64'(pass_cnt), 64'h0);
        chk("idle_spurious_busy", 64'(busy), 64'h0);

        // Run 1: all pass, backpressure on idx 2; first vector two edges after start.
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        chk("lat_busy", 64'(busy), 64'h1);
        chk("lat_valid_early", 64'(vec_valid), 64'h0);
        @(negedge CLK);
        chk("lat_valid", 64'(vec_valid), 64'h1);
        serve(16'h0000, 2, -1);
        end_checks(16, 0, 1'b0, 64'h0, 64'h0, 64'h0);

        // Run 2: failures on idx 3 and 9; first failure is the idx 3 corner.
        pulse_start();
        chk("rerun_pass_clr", 64'(pass_cnt), 64'h0);
        chk("rerun_done_clr", 64'(done), 64'h0);
        serve(16'h0208, -1, -1);
        end_checks(14, 2, 1'b1, MAXV, 64'h1, MAXV);

        // Run 3: async reset while waiting on idx 5's verdict.
        pulse_start();
        chk("run3_fail_seen_clr", 64'(fail_seen), 64'h0);
        serve(16'h0000, -1, 5);
        chk("pre_rst_pass", 64'(pass_cnt), 64'h5);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_done", 64'(done), 64'h0);
        chk("arst_pass_cnt", 64'(pass_cnt), 64'h0);
        chk("arst_prop_base", prop_base, 64'h0);
        chk("arst_prop_len", prop_len, 64'h0);
        @(negedge CLK); RST_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_busy", 64'(busy), 64'h0);

        // Run 4: same seed, same stream.
        pulse_start();
        serve(16'h0000, -1, -1);
        end_checks(16, 0, 1'b0, 64'h0, 64'h0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
